// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared register selects, limits and vector helper
package interrupt_controller_pkg;

  localparam int MAX_IRQ = 8;

  localparam logic [1:0] REG_ENABLE    = 2'd0;
  localparam logic [1:0] REG_MODE      = 2'd1;
  localparam logic [1:0] REG_PENDING   = 2'd2;
  localparam logic [1:0] REG_INSERVICE = 2'd3;

  function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [2:0]  idx);
    return base + stride * {13'd0, idx};
  endfunction

endpackage

// File: rtl/interrupt_controller_sync.sv
// rtl/interrupt_controller_sync.sv - per-bit synchroniser with rising-edge detect
module irq_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) chain[s] <= '0;
      hist <= '0;
    end else begin
      chain[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
      hist <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised nestable interrupt controller with vector output
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          N_IRQ         = 8,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [15:0] VECTOR_BASE   = 16'h0002,
  parameter int          VECTOR_STRIDE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [N_IRQ-1:0] irq_clr,
  output logic             irq_req,
  output logic [15:0]      irq_vector,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  input  logic [1:0]       reg_sel,
  input  logic             reg_we,
  input  logic             reg_re,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata
);

  localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);

  logic [N_IRQ-1:0] enable_q, mode_q, pend_q, insvc_q, clr_q;
  logic [N_IRQ-1:0] sync_level, sync_rise;
  logic             req_q;
  logic [15:0]      vector_q;

  logic [N_IRQ-1:0] insvc_eoi, elig_ack, ack_onehot, sw_clr, pend_d, insvc_d, pend_kept, elig_d;
  logic             ack_take;
  logic [2:0]       ack_idx, win_d;
  logic             unused_ok;

  assign unused_ok = reg_re ^ (^reg_wdata);

  irq_sync_edge #(.WIDTH(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (irq_in),
    .level (sync_level),
    .rise  (sync_rise)
  );

  // Only sources strictly higher in priority than the most urgent in-service one may preempt.
  function automatic logic [N_IRQ-1:0] prio_mask(input logic [N_IRQ-1:0] isv);
    logic [N_IRQ-1:0] low;
    low = isv & (~isv + ONE);
    return (isv == '0) ? '1 : (low - ONE);
  endfunction

  function automatic logic [2:0] lowest(input logic [N_IRQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  always_comb begin
    insvc_eoi  = irq_eoi ? (insvc_q & (insvc_q - ONE)) : insvc_q;
    elig_ack   = pend_q & enable_q & prio_mask(insvc_eoi);
    ack_take   = irq_ack && (req_q || irq_eoi) && (elig_ack != '0);
    ack_idx    = lowest(elig_ack);
    ack_onehot = ack_take ? (ONE << ack_idx) : '0;
    insvc_d    = insvc_eoi | ack_onehot;
    sw_clr     = (reg_we && reg_sel == REG_PENDING) ? reg_wdata[N_IRQ-1:0] : '0;
    for (int i = 0; i < N_IRQ; i++) begin
      pend_d[i] = mode_q[i] ? (sync_rise[i] | (pend_q[i] & ~ack_onehot[i] & ~sw_clr[i]))
                            : sync_level[i];
    end
    // Request tracks post-ack state but sees new pending bits and register writes a cycle later.
    pend_kept = pend_q & ~(ack_onehot & mode_q);
    elig_d    = pend_kept & enable_q & prio_mask(insvc_d);
    win_d     = lowest(elig_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      insvc_q  <= '0;
      clr_q    <= '0;
      req_q    <= 1'b0;
      vector_q <= VECTOR_BASE;
    end else begin
      if (reg_we && reg_sel == REG_ENABLE) enable_q <= reg_wdata[N_IRQ-1:0];
      if (reg_we && reg_sel == REG_MODE)   mode_q   <= reg_wdata[N_IRQ-1:0];
      pend_q   <= pend_d;
      insvc_q  <= insvc_d;
      clr_q    <= ack_onehot;
      req_q    <= |elig_d;
      vector_q <= (|elig_d) ? calc_vector(VECTOR_BASE, 16'(VECTOR_STRIDE), win_d) : VECTOR_BASE;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_ENABLE:    reg_rdata[N_IRQ-1:0] = enable_q;
      REG_MODE:      reg_rdata[N_IRQ-1:0] = mode_q;
      REG_PENDING:   reg_rdata[N_IRQ-1:0] = pend_q;
      REG_INSERVICE: reg_rdata[N_IRQ-1:0] = insvc_q;
      default:       reg_rdata = '0;
    endcase
  end

  assign irq_clr    = clr_q;
  assign irq_req    = req_q;
  assign irq_vector = vector_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized and directed bench against a behavioural model
module tb_interrupt_controller;

  localparam int N      = 8;
  localparam int SS     = 2;
  localparam int BASE   = 16'h0002;
  localparam int STRIDE = 2;
  localparam int FULL   = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic [N-1:0] irq_clr;
  logic         irq_req;
  logic [15:0]  irq_vector;
  logic         irq_ack = 1'b0;
  logic         irq_eoi = 1'b0;
  logic [1:0]   reg_sel = 2'd0;
  logic         reg_we = 1'b0;
  logic         reg_re = 1'b0;
  logic [7:0]   reg_wdata = '0;
  logic [7:0]   reg_rdata;

  always #5 clk = ~clk;

  interrupt_controller #(.N_IRQ(N), .SYNC_STAGES(SS), .VECTOR_BASE(16'h0002), .VECTOR_STRIDE(STRIDE)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_clr(irq_clr), .irq_req(irq_req),
    .irq_vector(irq_vector), .irq_ack(irq_ack), .irq_eoi(irq_eoi), .reg_sel(reg_sel),
    .reg_we(reg_we), .reg_re(reg_re), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  int checks = 0;
  int errors = 0;

  int m_en, m_mode, m_pend, m_isv, m_req, m_vec, m_clr;
  int in_q[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_idx(input int v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int allowed(input int isv);
    int lo;
    lo = lowest_idx(isv);
    if (lo < 0) return FULL;
    return (1 << lo) - 1;
  endfunction

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_pend = 0; m_isv = 0; m_req = 0; m_vec = BASE; m_clr = 0;
    in_q.delete();
    for (int i = 0; i <= SS; i++) in_q.push_back(0);
  endtask

  // Input seen SS edges ago is the synchronised level; one more edge back is its history.
  task automatic model_step();
    int lvl, prev, rise, isv2, elig, swclr, ackclr, npend, kept, e2;
    lvl  = in_q[SS-1];
    prev = in_q[SS];
    rise = lvl & ~prev & FULL;
    isv2 = m_isv;
    if (irq_eoi && isv2 != 0) isv2 = isv2 & ~(1 << lowest_idx(isv2));
    elig   = m_pend & m_en & allowed(isv2);
    ackclr = 0;
    if (irq_ack && (m_req != 0 || irq_eoi) && elig != 0) begin
      ackclr = 1 << lowest_idx(elig);
      isv2   = isv2 | ackclr;
    end
    swclr = (reg_we && reg_sel == 2'd2) ? int'(reg_wdata) : 0;
    npend = (((rise | (m_pend & ~ackclr & ~swclr)) & m_mode) | (lvl & ~m_mode)) & FULL;
    kept  = m_pend & ~(ackclr & m_mode);
    e2    = kept & m_en & allowed(isv2);
    m_req = (e2 != 0) ? 1 : 0;
    m_vec = m_req != 0 ? ((BASE + lowest_idx(e2) * STRIDE) & 16'hFFFF) : BASE;
    m_clr = ackclr;
    if (reg_we && reg_sel == 2'd0) m_en = int'(reg_wdata);
    if (reg_we && reg_sel == 2'd1) m_mode = int'(reg_wdata);
    m_pend = npend;
    m_isv  = isv2;
    in_q.push_front(int'(irq_in));
    void'(in_q.pop_back());
  endtask

  function automatic int model_rdata(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_en;
      2'd1:    return m_mode;
      2'd2:    return m_pend;
      default: return m_isv;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("req", int'(irq_req), m_req);
    check("vector", int'(irq_vector), m_vec);
    check("clr", int'(irq_clr), m_clr);
    check("rdata", int'(reg_rdata), model_rdata(reg_sel));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    reg_sel = sel; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic eoi();
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
  endtask

  task automatic pulse(input int src);
    irq_in[src] = 1'b1; tick(); irq_in[src] = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [1:0] sel, input int exp);
    reg_sel = sel;
    #1;
    check(tag, int'(reg_rdata), exp);
  endtask

  task automatic drain();
    for (int k = 0; k < 32; k++) begin
      if (m_req != 0) ack();
      else if (m_isv != 0) eoi();
      else tick();
    end
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_req", int'(irq_req), 0);
    check("rst_vector", int'(irq_vector), 16'h0002);
    check("rst_clr", int'(irq_clr), 0);
    check("rst_enable", int'(reg_rdata), 0);
    reset = 1'b1;

    // single edge source 0
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h01);
    pulse(0);
    idle(2);
    check("t1_req_early", int'(irq_req), 0);
    tick();
    check("t1_req", int'(irq_req), 1);
    check("t1_vector", int'(irq_vector), 16'h0002);
    ack();
    check("t1_clr", int'(irq_clr), 1);
    check("t1_req_post", int'(irq_req), 0);
    peek("t1_insvc", 2'd3, 8'h01);
    tick();
    check("t1_clr_once", int'(irq_clr), 0);
    eoi();
    ack();
    eoi();
    peek("stray_insvc", 2'd3, 0);
    peek("stray_pend", 2'd2, 0);

    // two pending edges, priority order
    wr(2'd0, 8'h0C);
    wr(2'd1, 8'h0C);
    irq_in = 8'h0C; tick(); irq_in = 8'h00;
    idle(3);
    check("t2_vec2", int'(irq_vector), 16'h0006);
    ack();
    eoi();
    check("t2_vec3", int'(irq_vector), 16'h0008);
    check("t2_req3", int'(irq_req), 1);

    // nesting with source 3 in service
    ack();
    wr(2'd0, 8'h2A);
    wr(2'd1, 8'h2A);
    pulse(5);
    idle(4);
    check("t3_masked", int'(irq_req), 0);
    pulse(1);
    idle(3);
    check("t3_req", int'(irq_req), 1);
    check("t3_vector", int'(irq_vector), 16'h0004);
    ack();
    peek("t3_insvc_nest", 2'd3, 8'h0A);
    eoi();
    check("t3_insvc_eoi", int'(reg_rdata), 8'h08);
    drain();

    // level-mode source 4
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h10);
    irq_in = 8'h10;
    idle(4);
    check("t4_req", int'(irq_req), 1);
    check("t4_vector", int'(irq_vector), 16'h000A);
    ack();
    peek("t4_insvc", 2'd3, 8'h10);
    peek("t4_pend", 2'd2, 8'h10);
    wr(2'd2, 8'h10);
    check("t4_pend_swclr", int'(reg_rdata), 8'h10);
    irq_in = 8'h00;
    idle(3);
    eoi();
    peek("t4_pend_drop", 2'd2, 0);
    check("t4_req_drop", int'(irq_req), 0);

    // same-cycle edge set and software clear on source 6
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h40);
    irq_in = 8'h40; tick(); tick();
    wr(2'd2, 8'h40);
    irq_in = 8'h00;
    peek("t5_set_wins", 2'd2, 8'h40);
    wr(2'd2, 8'h40);
    check("t5_swclr", int'(reg_rdata), 0);

    // ack and eoi together
    wr(2'd1, 8'h05);
    wr(2'd0, 8'h05);
    pulse(0);
    idle(3);
    ack();
    pulse(2);
    idle(3);
    check("t6_masked", int'(irq_req), 0);
    irq_ack = 1'b1; irq_eoi = 1'b1; tick(); irq_ack = 1'b0; irq_eoi = 1'b0;
    peek("t6_insvc", 2'd3, 8'h04);
    drain();

    // asynchronous reset mid-handshake
    pulse(0);
    idle(3);
    check("t7_req_pre", int'(irq_req), 1);
    irq_ack = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("t7_req", int'(irq_req), 0);
    check("t7_vector", int'(irq_vector), 16'h0002);
    check("t7_clr", int'(irq_clr), 0);
    peek("t7_insvc", 2'd3, 0);
    @(posedge clk);
    #1;
    check("t7_clr_held", int'(irq_clr), 0);
    irq_ack = 1'b0;
    #2;
    reset = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) irq_in = irq_in ^ (8'(1) << $urandom_range(0, 7));
      irq_ack   = ((m_req != 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 40) == 0);
      irq_eoi   = ($urandom_range(0, 7) == 0);
      reg_we    = ($urandom_range(0, 15) == 0);
      reg_sel   = 2'($urandom_range(0, 3));
      reg_wdata = 8'($urandom);
      tick();
    end
    irq_ack = 1'b0; irq_eoi = 1'b0; reg_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
